// File: rtl/frequency_pkg.sv
// Shared definitions for the frequency measurement window controller:
// state encoding, symbol codes, settle length and counter widths.
package frequency_pkg;

    // Counter and field widths
    localparam int STATE_W  = 3;
    localparam int COUNT_W  = 32;
    localparam int SYM_W    = 2;
    localparam int OVR_W    = 16;
    localparam int SETTLE_W = 2;

    // Window sequencer states
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_LATCH   = 3'd4
    } state_e;

    // Classification result codes; code 3 is never produced
    localparam logic [SYM_W-1:0] SYM_NONE = 2'd0;
    localparam logic [SYM_W-1:0] SYM_F1   = 2'd1;
    localparam logic [SYM_W-1:0] SYM_F2   = 2'd2;

    // Cycles with the analyzer idle before its outputs are sampled
    localparam int SETTLE_TICKS = 2;

    // Saturating increment for the overrun counter
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        if (v == {OVR_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/tone_classifier.sv
// Combinational window classifier: picks the dominant tone when its count
// is strictly larger than the other and reaches the acceptance threshold.
// Equal counts never yield a tone.
module tone_classifier
    import frequency_pkg::*;
(
    input  logic [COUNT_W-1:0] f1,
    input  logic [COUNT_W-1:0] f2,
    input  logic [COUNT_W-1:0] min_count,
    output logic [SYM_W-1:0]   symbol
);

    // Unsigned compares; strict inequality makes ties fall through to none
    always_comb begin
        symbol = SYM_NONE;
        if ((f1 > f2) && (f1 >= min_count)) begin
            symbol = SYM_F1;
        end else if ((f2 > f1) && (f2 >= min_count)) begin
            symbol = SYM_F2;
        end
    end

endmodule

// File: rtl/frequency_window_controller.sv
// Sequences an external frequency analyzer through fixed-length windows:
// clear, measure for WINDOW_TICKS clocks, settle, then latch and classify.
// The classified result is offered downstream on a valid/ready port.
//
// Handshake: a result transfers on any rising edge where result_valid and
// result_ready are both high. While result_valid is high and result_ready is
// low, the symbol and latched values are held. A new result loading on the
// same edge as a transfer keeps result_valid high with the new data; a new
// result loading while the old one is still unconsumed overwrites it and
// raises a one-cycle overrun pulse.
module frequency_window_controller
    import frequency_pkg::*;
#(
    parameter int unsigned WINDOW_TICKS = 50000,
    parameter int unsigned MIN_COUNT    = 12500
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 run,
    input  logic                 abort,
    input  logic [COUNT_W-1:0]   f1_value,
    input  logic [COUNT_W-1:0]   f2_value,
    output logic                 analyzer_enable,
    output logic                 analyzer_clear,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [SYM_W-1:0]     result_symbol,
    output logic [COUNT_W-1:0]   f1_latched,
    output logic [COUNT_W-1:0]   f2_latched,
    output logic                 overrun,
    output logic [OVR_W-1:0]     overrun_count,
    output logic [STATE_W-1:0]   debug_state
);

    // Plain-vector state constants mirroring the package enum
    localparam logic [STATE_W-1:0] S_IDLE    = ST_IDLE;
    localparam logic [STATE_W-1:0] S_CLEAR   = ST_CLEAR;
    localparam logic [STATE_W-1:0] S_MEASURE = ST_MEASURE;
    localparam logic [STATE_W-1:0] S_SETTLE  = ST_SETTLE;
    localparam logic [STATE_W-1:0] S_LATCH   = ST_LATCH;

    localparam logic [COUNT_W-1:0]  WIN_LOAD   = COUNT_W'(WINDOW_TICKS);
    localparam logic [COUNT_W-1:0]  MIN_CNT    = COUNT_W'(MIN_COUNT);
    localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SETTLE_TICKS - 1);

    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_nxt;
    logic [COUNT_W-1:0]  win_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SYM_W-1:0]    sym_new;
    logic                load_result;

    assign debug_state = state;

    // A result is captured only when LATCH completes without an abort
    assign load_result = (state == S_LATCH) && !abort;

    tone_classifier u_classifier (
        .f1        (f1_value),
        .f2        (f2_value),
        .min_count (MIN_CNT),
        .symbol    (sym_new)
    );

    // Next-state decode; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                if (win_cnt == COUNT_W'(1)) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_END) begin
                    state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                state_nxt = run ? S_CLEAR : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Window down-counter loaded in CLEAR, so MEASURE lasts WINDOW_TICKS
    // cycles; settle counter runs only while in SETTLE
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            win_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == S_CLEAR) begin
                win_cnt <= WIN_LOAD;
            end else if (state == S_MEASURE) begin
                win_cnt <= win_cnt - 1'b1;
            end
            if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    // Analyzer controls registered from the next state so they are
    // glitch-free and track the state they belong to cycle-for-cycle
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            analyzer_clear  <= 1'b1;
            analyzer_enable <= 1'b0;
        end else begin
            analyzer_clear  <= (state_nxt == S_IDLE) || (state_nxt == S_CLEAR);
            analyzer_enable <= (state_nxt == S_MEASURE);
        end
    end

    // Result register, valid/ready handshake and overrun tracking
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            result_valid  <= 1'b0;
            result_symbol <= SYM_NONE;
            f1_latched    <= '0;
            f2_latched    <= '0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            overrun <= 1'b0;
            if (load_result) begin
                result_valid  <= 1'b1;
                result_symbol <= sym_new;
                f1_latched    <= f1_value;
                f2_latched    <= f2_value;
                if (result_valid && !result_ready) begin
                    overrun       <= 1'b1;
                    overrun_count <= sat_inc(overrun_count);
                end
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frequency_window_controller.sv
// Directed bench for frequency_window_controller with a behavioural
// analyzer model and an expected-result queue.
module tb_frequency_window_controller;
    import frequency_pkg::*;

    localparam int unsigned WT  = 100;
    localparam int unsigned MIN = 25;
    localparam int          W   = 66;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic clear_n = 1'b0;
    always #5 clock = ~clock;

    logic               run = 1'b0;
    logic               abort = 1'b0;
    logic               result_ready = 1'b0;
    logic [31:0]        f1_value;
    logic [31:0]        f2_value;
    logic               analyzer_enable;
    logic               analyzer_clear;
    logic               result_valid;
    logic [1:0]         result_symbol;
    logic [31:0]        f1_latched;
    logic [31:0]        f2_latched;
    logic               overrun;
    logic [15:0]        overrun_count;
    logic [2:0]         debug_state;

    frequency_window_controller #(
        .WINDOW_TICKS (WT),
        .MIN_COUNT    (MIN)
    ) dut (
        .clock           (clock),
        .clear_n         (clear_n),
        .run             (run),
        .abort           (abort),
        .f1_value        (f1_value),
        .f2_value        (f2_value),
        .analyzer_enable (analyzer_enable),
        .analyzer_clear  (analyzer_clear),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_symbol   (result_symbol),
        .f1_latched      (f1_latched),
        .f2_latched      (f2_latched),
        .overrun         (overrun),
        .overrun_count   (overrun_count),
        .debug_state     (debug_state)
    );

    // ---------------- analyzer model ----------------
    // Counts enabled cycles since the last clear; each tone reading saturates
    // at its programmed target, so after a full window it equals the target.
    logic [31:0] en_cnt = 32'd0;
    logic [31:0] tone1 = 32'd0;
    logic [31:0] tone2 = 32'd0;
    always @(posedge clock) begin
        if (analyzer_clear) en_cnt <= 32'd0;
        else if (analyzer_enable) en_cnt <= en_cnt + 32'd1;
    end
    assign f1_value = (en_cnt < tone1) ? en_cnt : tone1;
    assign f2_value = (en_cnt < tone2) ? en_cnt : tone2;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned ovr_seen = 0;
    always @(negedge clock) if (overrun) ovr_seen <= ovr_seen + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_sym(input logic [31:0] a, input logic [31:0] b);
        if (a > b && a >= MIN) return 2'd1;
        if (b > a && b >= MIN) return 2'd2;
        return 2'd0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_tone(input logic [31:0] a, input logic [31:0] b, input bit push);
        logic [31:0] ea;
        logic [31:0] eb;
        tone1 = a;
        tone2 = b;
        if (push) begin
            ea = (a < WT) ? a : WT;
            eb = (b < WT) ? b : WT;
            exp_q.push_back({exp_sym(ea, eb), ea, eb});
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sym"}, {30'd0, result_symbol}, {30'd0, e[65:64]});
            check({tag, "_f1"}, f1_latched, e[63:32]);
            check({tag, "_f2"}, f2_latched, e[31:0]);
        end
    endtask

    // Wait for a new result: valid rising, or an overrun pulse when an old
    // result is still being held
    task automatic wait_load(input string tag, input bit use_ovr);
        int n;
        bit hit;
        hit = 1'b0;
        for (n = 0; n < 2 * WT + 50; n++) begin
            tick();
            if (use_ovr ? overrun : result_valid) begin
                hit = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, {31'd0, hit}, 32'd1);
        pop_compare(tag);
    endtask

    task automatic start_window();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] pairs [6][2];

    initial begin
        int n;
        int unsigned t0;
        int unsigned ovr_base;
        bit hit;

        pairs[0] = '{32'd40, 32'd40};
        pairs[1] = '{32'd20, 32'd3};
        pairs[2] = '{32'd0,  32'd60};
        pairs[3] = '{32'd25, 32'd0};
        pairs[4] = '{32'd24, 32'd0};
        pairs[5] = '{32'd60, 32'd61};

        // Reset state
        tick();
        tick();
        check("rst_state", {29'd0, debug_state}, {29'd0, ST_IDLE});
        check("rst_clear", {31'd0, analyzer_clear}, 32'd1);
        check("rst_enable", {31'd0, analyzer_enable}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_ovr_cnt", {16'd0, overrun_count}, 32'd0);
        clear_n = 1'b1;
        tick();
        check("idle_state", {29'd0, debug_state}, {29'd0, ST_IDLE});

        // Tone 1 window: enable length and result latency
        result_ready = 1'b1;
        set_tone(32'd80, 32'd5, 1'b1);
        run = 1'b1;
        tick();
        t0 = cyc;
        run = 1'b0;
        check("t1_clear_state", {29'd0, debug_state}, {29'd0, ST_CLEAR});
        check("t1_clear_out", {31'd0, analyzer_clear}, 32'd1);
        check("t1_enable_off", {31'd0, analyzer_enable}, 32'd0);
        n = 0;
        tick();
        while (analyzer_enable && n < 3 * WT) begin
            n++;
            tick();
        end
        check("t1_enable_len", n, WT);
        wait_load("t1", 1'b0);
        check("t1_latency", cyc - t0, WT + 4);

        // Ties, weak tones and threshold boundaries
        for (int i = 0; i < 6; i++) begin
            set_tone(pairs[i][0], pairs[i][1], 1'b1);
            start_window();
            wait_load($sformatf("cls%0d", i), 1'b0);
        end

        // Run drops mid-MEASURE: window completes, then IDLE
        set_tone(32'd0, 32'd60, 1'b1);
        run = 1'b1;
        tick();
        repeat (30) tick();
        run = 1'b0;
        wait_load("rundrop", 1'b0);
        repeat (3) tick();
        check("rundrop_idle", {29'd0, debug_state}, {29'd0, ST_IDLE});
        check("rundrop_clear", {31'd0, analyzer_clear}, 32'd1);
        check("rundrop_valid", {31'd0, result_valid}, 32'd0);

        // Abort mid-MEASURE: IDLE next cycle, no result
        set_tone(32'd80, 32'd5, 1'b0);
        start_window();
        repeat (20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {29'd0, debug_state}, {29'd0, ST_IDLE});
        check("abort_clear", {31'd0, analyzer_clear}, 32'd1);
        check("abort_enable", {31'd0, analyzer_enable}, 32'd0);
        hit = 1'b0;
        repeat (WT + 20) begin
            tick();
            if (result_valid) hit = 1'b1;
        end
        check("abort_no_valid", {31'd0, hit}, 32'd0);

        // Overrun: three back-to-back windows with ready low
        result_ready = 1'b0;
        ovr_base = ovr_seen;
        set_tone(32'd80, 32'd5, 1'b1);
        run = 1'b1;
        wait_load("ovr_w1", 1'b0);
        set_tone(32'd40, 32'd40, 1'b1);
        wait_load("ovr_w2", 1'b1);
        check("ovr_cnt1", {16'd0, overrun_count}, 32'd1);
        set_tone(32'd0, 32'd60, 1'b1);
        wait_load("ovr_w3", 1'b1);
        check("ovr_cnt2", {16'd0, overrun_count}, 32'd2);
        tick();
        check("ovr_pulse_len", {31'd0, overrun}, 32'd0);
        check("ovr_held_sym", {30'd0, result_symbol}, 32'd2);
        check("ovr_pulses", ovr_seen - ovr_base, 32'd2);

        // Fourth window: ready raised on the LATCH edge, no overrun
        run = 1'b0;
        set_tone(32'd20, 32'd3, 1'b1);
        hit = 1'b0;
        for (n = 0; n < 2 * WT; n++) begin
            if (debug_state == ST_LATCH) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("w4_latch_timeout", {31'd0, hit}, 32'd1);
        result_ready = 1'b1;
        tick();
        check("w4_no_overrun", {31'd0, overrun}, 32'd0);
        check("w4_valid", {31'd0, result_valid}, 32'd1);
        check("w4_ovr_cnt", {16'd0, overrun_count}, 32'd2);
        pop_compare("w4");
        tick();
        check("w4_consumed", {31'd0, result_valid}, 32'd0);
        check("w4_idle", {29'd0, debug_state}, {29'd0, ST_IDLE});

        // Reset mid-window with a held result and nonzero overrun count
        result_ready = 1'b0;
        set_tone(32'd0, 32'd60, 1'b1);
        run = 1'b1;
        wait_load("rstA", 1'b0);
        repeat (20) tick();
        check("pre_rst_enable", {31'd0, analyzer_enable}, 32'd1);
        #2;
        clear_n = 1'b0;
        #1;
        check("arst_state", {29'd0, debug_state}, {29'd0, ST_IDLE});
        check("arst_clear", {31'd0, analyzer_clear}, 32'd1);
        check("arst_enable", {31'd0, analyzer_enable}, 32'd0);
        check("arst_valid", {31'd0, result_valid}, 32'd0);
        check("arst_sym", {30'd0, result_symbol}, 32'd0);
        check("arst_f1", f1_latched, 32'd0);
        check("arst_f2", f2_latched, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        check("arst_ovr_cnt", {16'd0, overrun_count}, 32'd0);
        tick();
        tick();
        clear_n = 1'b1;
        result_ready = 1'b1;
        set_tone(32'd80, 32'd5, 1'b1);
        tick();
        check("rst_restart_clear", {29'd0, debug_state}, {29'd0, ST_CLEAR});
        run = 1'b0;
        wait_load("rst_restart", 1'b0);

        check("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/frequency_window_controller.md
# frequency_window_controller

Sequences a `frequency_analyzer` instance through fixed-length measurement windows. Each window clears the analyzer, enables it for `WINDOW_TICKS` clocks, then latches its `f1_value`/`f2_value` outputs and classifies the window as tone 1, tone 2 or none. The result is presented on a valid/ready port to the downstream symbol/bit decoder of the FSK receive path.

## Interface
- `WINDOW_TICKS`, 50000: measurement window length in clocks (1 ms at 50 MHz); ≥ 4.
- `MIN_COUNT`, 12500: minimum accumulated in-band ticks for a tone to be accepted.
- `clock` in 1: system clock; all logic on rising edge.
- `clear_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; while high, windows repeat back-to-back.
- `abort` in 1: synchronous; ends the current window immediately and returns to IDLE.
- `f1_value` in 32: analyzer tone-1 accumulated ticks.
- `f2_value` in 32: analyzer tone-2 accumulated ticks.
- `analyzer_enable` out 1: drives the analyzer `enable` input.
- `analyzer_clear` out 1: drives the analyzer `clear` input (active high); registered, glitch-free.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `result_symbol` out 2: 0 = none, 1 = tone 1, 2 = tone 2; 3 is never produced.
- `f1_latched`, `f2_latched` out 32 each: analyzer values captured for the presented result.
- `overrun` out 1: one-cycle pulse when an unconsumed result is overwritten.
- `overrun_count` out 16: saturating count of overruns.

## Operation
- States: IDLE, CLEAR, MEASURE, SETTLE, LATCH.
- IDLE: `analyzer_clear`=1, `analyzer_enable`=0. If `run`=1 and `abort`=0, go to CLEAR.
- CLEAR: one cycle with `analyzer_clear`=1, then MEASURE.
- MEASURE: `analyzer_enable`=1 for exactly `WINDOW_TICKS` cycles, counted by a 32-bit down-counter loaded in CLEAR. Then SETTLE.
- SETTLE: 2 cycles with enable=0 and clear=0, so the analyzer outputs are stable. Then LATCH.
- LATCH: one cycle; capture `f1_value`/`f2_value` and compute the symbol. Next state is CLEAR if `run`=1, else IDLE.
- Classification, unsigned 32-bit compares:
  - symbol 1 if f1 > f2 and f1 ≥ `MIN_COUNT`.
  - symbol 2 if f2 > f1 and f2 ≥ `MIN_COUNT`.
  - otherwise 0, including equal counts.
- `run` falling during CLEAR/MEASURE/SETTLE: the window completes and its result is delivered; the FSM then goes to IDLE.
- `abort`=1 in any state: next state is IDLE. No result is produced and no latch occurs. `abort` has priority over `run` and over LATCH.
- Reset (`clear_n`=0), at any time including mid-window:
  - state IDLE, `analyzer_clear`=1, `analyzer_enable`=0.
  - `result_valid`=0, `result_symbol`=0, latched values 0.
  - `overrun`=0, `overrun_count`=0.

## Timing
- Window period is `WINDOW_TICKS`+4 clocks: CLEAR 1, MEASURE N, SETTLE 2, LATCH 1.
- `run` sampled high in IDLE at edge k: CLEAR is active in cycle k+1, and `analyzer_enable` first goes high in cycle k+2.
- Result registers and `result_valid` update on the edge that ends LATCH, so they are visible the cycle after LATCH.
- Handshake:
  - Transfer occurs when `result_valid` & `result_ready` are both high on a rising edge.
  - `result_valid` then drops unless a new result loads on the same edge; in that case it stays high with the new data.
  - While `result_valid`=1 and `result_ready`=0, all result outputs are held stable.
- Overrun:
  - LATCH-end edge with `result_valid`=1 and `result_ready`=0: the new result overwrites the old, `overrun` pulses for 1 cycle, and `overrun_count` increments, saturating at 65535.
  - LATCH-end edge with valid & ready both high: the old result transfers, the new one loads, and there is no overrun.

## Structure
- Shared package `frequency_pkg`:
  - state enum.
  - symbol constants SYM_NONE=0, SYM_F1=1, SYM_F2=2.
  - SETTLE_TICKS=2.
  - counter widths.
- Natural sub-module: `tone_classifier`, combinational. Inputs f1, f2, min_count; output symbol.
- The top is the FSM, the window counter and the result/handshake register.
- `frequency_analyzer` is instantiated alongside the block by the integrating top, not inside it.

## Test plan
- Tone 1 window: `WINDOW_TICKS`=100, `MIN_COUNT`=25, model drives f1=80, f2=5. Expect `analyzer_enable` high exactly 100 cycles, then `result_symbol`=1 with latched 80/5 at cycle 104 after CLEAR.
- Tie and weak tones:
  - f1=f2=40 → symbol 0.
  - f1=20, f2=3 → symbol 0 (below `MIN_COUNT`).
  - f2=60, f1=0 → symbol 2.
- Overrun: `result_ready`=0, `run`=1 for 3 windows. Expect `overrun` to pulse twice and `overrun_count`=2, with `result_symbol` equal to the third window's value. Then hold ready=1 on a LATCH edge: expect no overrun.
- Stop and abort:
  - `run` drops mid-MEASURE: the window completes, one result is delivered, then IDLE with `analyzer_clear`=1.
  - `abort` pulse mid-MEASURE: IDLE next cycle, no `result_valid`.
- Reset mid-window: drive `clear_n` low during MEASURE. Expect all outputs at reset values immediately (asynchronously), and `overrun_count`=0. After release with `run`=1, a full window restarts from CLEAR.
